sop_pipe: RTL and testbench
===========================

# sop_pipe

Parametrised, multi-channel successor to the team's registered sum-of-products detector. Per channel it flags "all inputs high", "all inputs low" and an external force bit, combines them under a selectable mode, and registers the result through a two-stage pipeline with valid/ready flow control. A saturating hit counter tracks delivered results with at least one asserted flag. It sits between an input sampling stage and downstream event logic that can apply backpressure.

## Interface
- W, default 3: input vector width per channel (≥2).
- NCH, default 4: number of independent channels (≥1).
- CNT_W, default 8: hit counter width.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_vec  input  NCH*W  channel c occupies bits [c*W+W-1 : c*W].
- in_f  input  NCH  per-channel force bit.
- mode  input  2  combine mode, sampled with the input word.
- out_valid  output  1  out_e holds a result.
- out_ready  input  1  downstream accepts the result.
- out_e  output  NCH  per-channel result flag.
- hit_cnt  output  CNT_W  saturating count of accepted results with any out_e bit set.
- clr_cnt  input  1  synchronous counter clear.

## Operation
- Stage 1 (on input handshake in_valid & in_ready), per channel c: d[c] = AND-reduce of channel vector; g[c] = NOR-reduce of channel vector; f[c] = in_f[c]; mode copied with the word.
- Stage 2, per channel, by stage-1 mode:
  - 0: e = d | g | f (legacy behaviour).
  - 1: e = d | g (force masked).
  - 2: e = (d | g) ^ f (force inverts).
  - 3: e = d & f (force-gated all-ones).
- Mode travels with its word; changing mode never alters words already in flight.
- Flow control: adv2 = ~out_valid | out_ready; stage 2 loads from stage 1 when adv2 and s1_valid. in_ready = ~s1_valid | adv2 (combinational, no dependency on in_valid). Stage 1 loads on input handshake; s1_valid clears when stage 1 is drained into stage 2 and no new word is accepted.
- While out_valid & ~out_ready: out_e and out_valid hold stable; a full stage 1 holds; in_ready = 0.
- Counter: on output handshake (out_valid & out_ready) with |out_e = 1, hit_cnt increments, saturating at 2^CNT_W−1 (no wrap). clr_cnt = 1 forces hit_cnt to 0 at the next edge and takes priority over a simultaneous increment (that hit is dropped).
- No data dependency between channels; each channel is fully independent apart from shared valid/mode.

## Timing
- Reset (rst_n low, asynchronous): s1_valid = 0, out_valid = 0, out_e = 0, hit_cnt = 0, all stage registers 0; in_ready = 1 while reset is held and immediately after release.
- Reset mid-operation discards all in-flight words; no partial result appears after release.
- Latency: word accepted at edge t → out_valid = 1 and out_e valid after edge t+1 (two register stages), provided out_ready was high.
- Throughput: one word per cycle with out_ready held high; no bubbles.
- Stall of N cycles buffers up to 2 words (stage 1 + stage 2); the third word is refused (in_ready = 0) until the stall ends.
- Simultaneous output handshake and stage-1 load in the same cycle is legal and required (pipeline slides).
- hit_cnt updates at the same edge as the counted output handshake.

## Test plan
- Reset: assert rst_n = 0 mid-stream with 2 words in flight → out_valid, out_e, hit_cnt = 0 immediately; after release in_ready = 1 and no stale output emerges.
- Legacy mode 0, W=3, NCH=4, out_ready = 1: in_vec channels {111, 000, 101, 010}, in_f = 4'b0100 → out_e = 4'b0111 after edge t+1; hit_cnt = 1.
- Modes 1/2/3 on the same vector sequence, mode changed every word → mode 1: 4'b0011; mode 2: 4'b0111 with in_f = 4'b1000 giving 4'b1011; mode 3 with in_f = 4'b0001: 4'b0001; each result matches the mode sent with its word.
- Backpressure: stream 5 words, out_ready = 0 for 4 cycles after first result → out_e held stable, in_ready drops after 2 buffered words, all 5 results delivered in order, none lost or duplicated.
- Counter saturation with CNT_W = 4: 20 hit results → hit_cnt stops at 15; results with out_e = 0 never count.
- clr_cnt asserted in the same cycle as a counted handshake → hit_cnt = 0 at next edge; next hit gives 1.

Source files
------------

// File: rtl/sop_pipe_if.sv
// Handshake bundle for sop_pipe: input word, result flags and hit counter.
// The producer/consumer side uses master; the pipeline itself uses slave.
interface sop_pipe_if #(
  parameter int W     = 3,
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [NCH*W-1:0] in_vec;
  logic [NCH-1:0]   in_f;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [NCH-1:0]   out_e;
  logic [CNT_W-1:0] hit_cnt;
  logic             clr_cnt;

  modport master (
    output in_valid, in_vec, in_f, mode,
    output out_ready, clr_cnt,
    input  in_ready, out_valid, out_e, hit_cnt
  );

  modport slave (
    input  in_valid, in_vec, in_f, mode,
    input  out_ready, clr_cnt,
    output in_ready, out_valid, out_e, hit_cnt
  );
endinterface

// File: rtl/sop_pipe.sv
// Multi-channel all-high/all-low/force detector, two-stage valid/ready
// pipeline with a saturating count of delivered non-zero results.
module sop_pipe #(
  parameter int W     = 3,
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  sop_pipe_if.slave bus
);
  typedef struct packed {
    logic [NCH-1:0] d;
    logic [NCH-1:0] g;
    logic [NCH-1:0] f;
    logic [1:0]     mode;
  } s1_t;

  localparam logic [CNT_W-1:0] CntMax = '1;

  s1_t              s1_q, s1_d, s1_new;
  logic             s1v_q, s1v_d;
  logic             ov_q, ov_d;
  logic [NCH-1:0]   e_q, e_d, e_new;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv2, acc, ohs;

  assign adv2          = ~ov_q | bus.out_ready;
  assign bus.in_ready  = ~s1v_q | adv2;
  assign acc           = bus.in_valid & bus.in_ready;
  assign ohs           = ov_q & bus.out_ready;
  assign bus.out_valid = ov_q;
  assign bus.out_e     = e_q;
  assign bus.hit_cnt   = cnt_q;

  always_comb begin
    s1_new      = '0;
    s1_new.f    = bus.in_f;
    s1_new.mode = bus.mode;
    for (int c = 0; c < NCH; c++) begin
      s1_new.d[c] = &bus.in_vec[c*W +: W];
      s1_new.g[c] = ~|bus.in_vec[c*W +: W];
    end
  end

  always_comb begin
    e_new = '0;
    unique case (1'b1)
      s1_q.mode == 2'd0: e_new = s1_q.d | s1_q.g | s1_q.f;
      s1_q.mode == 2'd1: e_new = s1_q.d | s1_q.g;
      s1_q.mode == 2'd2: e_new = (s1_q.d | s1_q.g) ^ s1_q.f;
      default:           e_new = s1_q.d & s1_q.f;
    endcase
  end

  always_comb begin
    s1_d  = s1_q;
    s1v_d = s1v_q;
    e_d   = e_q;
    ov_d  = ov_q;
    cnt_d = cnt_q;
    if (adv2) begin
      ov_d  = s1v_q;
      s1v_d = 1'b0;
      if (s1v_q) e_d = e_new;
    end
    if (acc) begin
      s1_d  = s1_new;
      s1v_d = 1'b1;
    end
    // clear wins over a coincident hit; that hit is dropped
    if (bus.clr_cnt) begin
      cnt_d = '0;
    end else if (ohs && |e_q && cnt_q != CntMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s1v_q <= 1'b0;
      e_q   <= '0;
      ov_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s1v_q <= s1v_d;
      e_q   <= e_d;
      ov_q  <= ov_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_sop_pipe.sv
// Scoreboard bench for sop_pipe: random and directed words, queue of
// expected flags, negedge monitor for results, ready and hit counter.
module tb_sop_pipe;
  localparam int W     = 3;
  localparam int NCH   = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic [NCH-1:0] e;
    int             n;
  } exp_t;

  logic clk;
  logic rst_n;
  sop_pipe_if #(.W(W), .NCH(NCH), .CNT_W(CNT_W)) bus ();

  sop_pipe #(.W(W), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   cnt_m = 0;
  int   delivered = 0;
  bit   acc_seen = 0;
  bit   rnd_on = 0;
  exp_t q[$];

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: per channel, classify the field, then apply the mode rule.
  function automatic logic [NCH-1:0] model(input logic [NCH*W-1:0] v,
                                           input logic [NCH-1:0] f,
                                           input logic [1:0] m);
    logic [NCH-1:0] r;
    int   ch;
    bit   ones, zeros;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      ch    = int'((v >> (c * W)) & ((1 << W) - 1));
      ones  = (ch == (1 << W) - 1);
      zeros = (ch == 0);
      case (m)
        2'd0: r[c] = ones || zeros || f[c];
        2'd1: r[c] = ones || zeros;
        2'd2: r[c] = (ones || zeros) != f[c];
        default: r[c] = ones && f[c];
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    logic [NCH-1:0] e;
    bit hs;
    cyc++;
    if (!rst_n) begin
      acc_seen = 0;
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) chk(0, "stale_out", bus.out_e, 0);
        else chk(bus.out_e == q[0].e, "out_e", bus.out_e, q[0].e);
      end else if (q.size() > 0 && cyc - q[0].n >= 2) begin
        chk(0, "latency_out_valid", 0, 1);
      end
      chk(bus.in_ready == (q.size() < 2 || bus.out_ready), "in_ready",
          bus.in_ready, (q.size() < 2 || bus.out_ready));
      chk(bus.hit_cnt == cnt_m, "hit_cnt", bus.hit_cnt, cnt_m);
      hs = bus.out_valid && bus.out_ready;
      e  = '0;
      if (hs && q.size() > 0) begin
        e = q.pop_front().e;
        delivered++;
      end
      if (bus.clr_cnt) cnt_m = 0;
      else if (hs && |e && cnt_m < CMAX) cnt_m++;
      acc_seen = bus.in_valid && bus.in_ready;
      if (acc_seen)
        q.push_back('{model(bus.in_vec, bus.in_f, bus.mode), cyc});
    end
  end

  task automatic send(input logic [NCH*W-1:0] v, input logic [NCH-1:0] f,
                      input logic [1:0] m);
    int k = 0;
    bus.in_vec   = v;
    bus.in_f     = f;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    do begin
      @(posedge clk);
      k++;
    end while (!acc_seen && k < 200);
    if (!acc_seen) chk(0, "send_timeout", k, 0);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    idle(2);
    chk(q.size() == 0, "drain", q.size(), 0);
  endtask

  task automatic pulse_clr();
    bus.clr_cnt = 1'b1;
    idle(1);
    bus.clr_cnt = 1'b0;
  endtask

  function automatic logic [NCH*W-1:0] rvec();
    logic [NCH*W-1:0] v;
    logic [W-1:0] ch;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      case ($urandom_range(0, 3))
        0: ch = '0;
        1: ch = '1;
        default: ch = W'($urandom);
      endcase
      v[c*W +: W] = ch;
    end
    return v;
  endfunction

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errs, checks);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    errs++;
    summary();
    $fatal(1, "watchdog");
  end

  localparam logic [NCH*W-1:0] V0 = {3'b010, 3'b101, 3'b000, 3'b111};
  localparam logic [NCH*W-1:0] VONES = '1;

  initial begin
    int d0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.in_f      = '0;
    bus.mode      = '0;
    bus.out_ready = 1'b1;
    bus.clr_cnt   = 1'b0;
    idle(2);
    chk(bus.out_valid == 1'b0, "rst_out_valid", bus.out_valid, 0);
    chk(bus.out_e == '0, "rst_out_e", bus.out_e, 0);
    chk(bus.hit_cnt == '0, "rst_hit_cnt", bus.hit_cnt, 0);
    chk(bus.in_ready == 1'b1, "rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    #1 chk(bus.in_ready == 1'b1, "post_rst_in_ready", bus.in_ready, 1);
    idle(1);

    // directed modes on the reference vector, mode changing every word
    send(V0, 4'b0100, 2'd0);
    send(V0, 4'b0100, 2'd1);
    send(V0, 4'b0000, 2'd2);
    send(V0, 4'b1000, 2'd2);
    send(V0, 4'b0001, 2'd3);
    drain();

    // backpressure: 5 words, 4-cycle stall once the first result shows
    d0 = delivered;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(rvec(), 4'($urandom), 2'($urandom));
      end
      begin
        int k = 0;
        do begin
          @(posedge clk);
          #1;
          k++;
        end while (!bus.out_valid && k < 50);
        bus.out_ready = 1'b0;
        idle(4);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk(delivered - d0 == 5, "bp_delivered", delivered - d0, 5);

    // randomized stream with random backpressure and rare clears
    rnd_on = 1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(rvec(), 4'($urandom), 2'($urandom));
          if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          bus.clr_cnt   = ($urandom_range(0, 40) == 0);
          idle(1);
        end
        bus.clr_cnt = 1'b0;
      end
    join
    drain();

    // saturation and zero-result words
    pulse_clr();
    for (int i = 0; i < 20; i++) send(VONES, 4'b0000, 2'd1);
    drain();
    chk(bus.hit_cnt == CNT_W'(CMAX), "sat_hit_cnt", bus.hit_cnt, CMAX);
    for (int i = 0; i < 5; i++) send(V0, 4'b0000, 2'd3);
    drain();
    chk(bus.hit_cnt == CNT_W'(CMAX), "zero_no_count", bus.hit_cnt, CMAX);

    // clear colliding with a counted handshake
    send(VONES, 4'b0000, 2'd1);
    idle(1);
    chk(bus.out_valid == 1'b1, "clr_setup_valid", bus.out_valid, 1);
    bus.clr_cnt = 1'b1;
    idle(1);
    bus.clr_cnt = 1'b0;
    chk(bus.hit_cnt == '0, "clr_priority", bus.hit_cnt, 0);
    send(VONES, 4'b0000, 2'd1);
    drain();
    chk(bus.hit_cnt == CNT_W'(1), "clr_then_hit", bus.hit_cnt, 1);

    // async reset with two words in flight
    bus.out_ready = 1'b0;
    send(VONES, 4'b0000, 2'd0);
    send(V0, 4'b1111, 2'd0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    q.delete();
    cnt_m = 0;
    #1;
    chk(bus.out_valid == 1'b0, "mid_rst_out_valid", bus.out_valid, 0);
    chk(bus.out_e == '0, "mid_rst_out_e", bus.out_e, 0);
    chk(bus.hit_cnt == '0, "mid_rst_hit_cnt", bus.hit_cnt, 0);
    chk(bus.in_ready == 1'b1, "mid_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk(bus.in_ready == 1'b1, "rel_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    idle(5);
    chk(bus.out_valid == 1'b0, "no_stale_after_rst", bus.out_valid, 0);
    send(V0, 4'b0100, 2'd0);
    drain();

    summary();
    $finish;
  end
endmodule
